// File: rtl/adc_scan_scheduler_if.sv
// Pin and sample-stream bundle between the ADC scan scheduler and its surroundings.
`timescale 1ns/1ps
interface adc_scan_scheduler_if;
  logic        enable;
  logic [7:0]  ch_mask;
  logic        ADC_CONVST;
  logic        ADC_SCLK;
  logic        ADC_SDI;
  logic        ADC_SDO;
  logic [11:0] sample_data;
  logic [2:0]  sample_ch;
  logic        sample_valid;
  logic        busy;

  modport master (
    input  enable, ch_mask, ADC_SDO,
    output ADC_CONVST, ADC_SCLK, ADC_SDI, sample_data, sample_ch, sample_valid, busy
  );

  modport slave (
    output enable, ch_mask, ADC_SDO,
    input  ADC_CONVST, ADC_SCLK, ADC_SDI, sample_data, sample_ch, sample_valid, busy
  );
endinterface

// File: rtl/adc_scan_scheduler.sv
// Round-robin scan sequencer for an LTC2308-style serial ADC with a pipelined
// channel-select word; emits each result as a tagged one-cycle strobe.
`timescale 1ns/1ps
module adc_scan_scheduler #(
  parameter int CLK_DIV       = 2,
  parameter int CONV_CYCLES   = 80,
  parameter int SAMPLE_PERIOD = 2500,
  parameter int NUM_CH        = 2
) (
  input logic                  CLOCK_50,
  input logic                  RESET_N,
  adc_scan_scheduler_if.master scan
);
  localparam int          PER_W    = $clog2(SAMPLE_PERIOD + 1);
  localparam logic [PER_W-1:0] PER_LOAD = PER_W'(SAMPLE_PERIOD - 1);
  localparam logic [15:0] CONV_LAST = 16'(CONV_CYCLES - 1);
  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [7:0]  CH_LIMIT  = 8'((1 << NUM_CH) - 1);

  typedef enum logic [2:0] {IDLE, CONV, SHIFT, DONE, WAIT} state_t;

  state_t            state, state_nx;
  logic [15:0]       cnt;
  logic [4:0]        half_cnt;
  logic [PER_W-1:0]  per_cnt;
  logic              prime;
  logic              sclk;
  logic [2:0]        cur_ch, next_ch, prev_ch, sel_ch;
  logic [11:0]       rx_sr, tx_sr;
  logic [11:0]       data_q;
  logic [2:0]        ch_q;
  logic              valid_q;
  logic [7:0]        em;
  logic              expired, run_ok, half_end, start;

  assign em       = scan.ch_mask & CH_LIMIT;
  assign expired  = (per_cnt == '0);
  assign run_ok   = scan.enable && (em != 8'd0);
  assign half_end = (cnt == DIV_LAST);
  assign start    = (state_nx == CONV) && (state != CONV);

  // First enabled channel strictly after cur_ch, wrapping back to cur_ch itself.
  always_comb begin
    int c;
    c      = 0;
    sel_ch = cur_ch;
    for (int i = NUM_CH; i >= 1; i--) begin
      c = (int'(cur_ch) + i) % NUM_CH;
      if (em[3'(c)]) sel_ch = 3'(c);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (run_ok && expired) state_nx = CONV;
      CONV:  if (cnt == CONV_LAST) state_nx = SHIFT;
      SHIFT: if (half_end && half_cnt == 5'd23) state_nx = DONE;
      DONE:  if (!run_ok) state_nx = IDLE;
             else if (expired) state_nx = CONV;
             else state_nx = WAIT;
      WAIT:  if (!run_ok) state_nx = IDLE;
             else if (expired) state_nx = CONV;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      cnt      <= '0;
      half_cnt <= '0;
      per_cnt  <= '0;
      prime    <= 1'b1;
      sclk     <= 1'b0;
      cur_ch   <= '0;
      next_ch  <= '0;
      prev_ch  <= '0;
      rx_sr    <= '0;
      tx_sr    <= '0;
      data_q   <= '0;
      ch_q     <= '0;
      valid_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (start) per_cnt <= PER_LOAD;
      else if (!expired) per_cnt <= per_cnt - 1'b1;

      case (state)
        CONV: begin
          if (cnt == CONV_LAST) begin
            cnt      <= '0;
            half_cnt <= '0;
            tx_sr    <= {1'b1, next_ch[0], next_ch[2], next_ch[1], 1'b1, 1'b0, 6'b0};
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        SHIFT: begin
          if (half_end) begin
            cnt      <= '0;
            half_cnt <= half_cnt + 5'd1;
            sclk     <= ~sclk;
            // Sample on the rising edge, advance the config word on the falling edge.
            if (!sclk) rx_sr <= {rx_sr[10:0], scan.ADC_SDO};
            else       tx_sr <= {tx_sr[10:0], 1'b0};
            if (half_cnt == 5'd23) begin
              data_q  <= rx_sr;
              ch_q    <= prev_ch;
              valid_q <= !prime;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DONE: begin
          valid_q <= 1'b0;
          prime   <= 1'b0;
          prev_ch <= next_ch;
          cur_ch  <= next_ch;
        end
        default: ;
      endcase

      if (start) begin
        next_ch <= sel_ch;
        cnt     <= '0;
      end
      // After an idle gap the ADC's pending selection is stale, so re-prime.
      if (state_nx == IDLE && state != IDLE) prime <= 1'b1;
    end
  end

  assign scan.ADC_CONVST   = (state == CONV);
  assign scan.ADC_SCLK     = sclk;
  assign scan.ADC_SDI      = tx_sr[11];
  assign scan.sample_data  = data_q;
  assign scan.sample_ch    = ch_q;
  assign scan.sample_valid = valid_q;
  assign scan.busy         = (state == CONV) || (state == SHIFT) || (state == DONE);
endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Directed bench for adc_scan_scheduler with a behavioural pipelined-config ADC model.
`timescale 1ns/1ps
module tb_adc_scan_scheduler;
  logic clk = 1'b0;
  logic rst_n;
  always #10 clk = ~clk;

  adc_scan_scheduler_if bus();
  adc_scan_scheduler_if fbus();

  adc_scan_scheduler u_dut (.CLOCK_50(clk), .RESET_N(rst_n), .scan(bus));
  adc_scan_scheduler #(.SAMPLE_PERIOD(64)) u_fast (.CLOCK_50(clk), .RESET_N(rst_n), .scan(fbus));

  int checks = 0;
  int errors = 0;

  // ADC model: config word captured in frame N selects the conversion of frame N+1.
  logic [11:0] cfg_sr = '0, pending = '0, out_sr = '0;
  int          cfg_bits = 0;
  logic [11:0] cfg_q[$];
  logic        in_conv = 1'b0;
  logic [2:0]  conv_ch;

  function automatic logic [11:0] adc_val(input logic [2:0] ch);
    return (ch == 3'd0) ? 12'hABC : (ch == 3'd1) ? 12'h123 : 12'h5A5;
  endfunction

  always @(posedge bus.ADC_SCLK) begin
    cfg_sr = {cfg_sr[10:0], bus.ADC_SDI};
    cfg_bits++;
    if (cfg_bits == 12) begin
      pending = cfg_sr;
      cfg_q.push_back(cfg_sr);
    end
  end

  always @(posedge bus.ADC_CONVST or negedge bus.ADC_CONVST or negedge bus.ADC_SCLK) begin
    if (bus.ADC_CONVST) begin
      conv_ch  = {pending[9], pending[8], pending[10]};
      cfg_bits = 0;
      in_conv  = 1'b1;
    end else if (in_conv) begin
      in_conv = 1'b0;
      out_sr  = adc_val(conv_ch);
      bus.ADC_SDO = out_sr[11];
    end else begin
      out_sr = {out_sr[10:0], 1'b0};
      bus.ADC_SDO = out_sr[11];
    end
  end

  // Event monitors, sampled on the falling clock edge.
  int cyc = 0, rise_cnt = 0, last_rise = 0, last_gap = 0;
  int hi_len = 0, conv_len = 0, pulses = 0, frame_pulses = 0, last_sclk = 0, bad_per = 0;
  int busy_hi = 0, f_rise = 0, f_last = 0, f_bad = 0, f_idle = 0;
  logic conv_q = 1'b0, sclk_q = 1'b0, fconv_q = 1'b0;
  logic [2:0]  st_ch[$];
  logic [11:0] st_data[$];

  always @(negedge clk) begin
    cyc++;
    if (bus.ADC_CONVST && !conv_q) begin
      rise_cnt++;
      if (rise_cnt > 1) last_gap = cyc - last_rise;
      last_rise    = cyc;
      frame_pulses = pulses;
      pulses       = 0;
    end
    if (bus.ADC_CONVST) hi_len++;
    else if (conv_q) begin
      conv_len = hi_len;
      hi_len   = 0;
    end
    if (bus.ADC_SCLK && !sclk_q) begin
      pulses++;
      if (pulses > 1 && (cyc - last_sclk) != 4) bad_per++;
      last_sclk = cyc;
    end
    if (bus.sample_valid) begin
      st_ch.push_back(bus.sample_ch);
      st_data.push_back(bus.sample_data);
    end
    if (bus.busy) busy_hi++;
    if (fbus.ADC_CONVST && !fconv_q) begin
      f_rise++;
      if (f_rise > 1 && (cyc - f_last) != 129) f_bad++;
      f_last = cyc;
    end
    if (f_rise >= 1 && !fbus.busy && rst_n) f_idle++;
    conv_q  = bus.ADC_CONVST;
    sclk_q  = bus.ADC_SCLK;
    fconv_q = fbus.ADC_CONVST;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_rises(input int n, input int budget);
    int k = 0;
    while (rise_cnt < n && k < budget) begin
      tick(1);
      k++;
    end
    chk("wait_convst_rise", 32'(rise_cnt >= n), 32'd1);
  endtask

  task automatic wait_pulses(input int n, input int budget);
    int k = 0;
    while (pulses < n && k < budget) begin
      tick(1);
      k++;
    end
    chk("wait_sclk_pulse", 32'(pulses >= n), 32'd1);
  endtask

  int snap_rise, snap_busy, snap_st;

  initial begin
    rst_n = 1'b0;
    bus.enable = 1'b1;  bus.ch_mask = 8'hFF;  bus.ADC_SDO = 1'b0;
    fbus.enable = 1'b1; fbus.ch_mask = 8'h03; fbus.ADC_SDO = 1'b0;
    tick(3);
    chk("reset_pins", {29'd0, bus.ADC_CONVST, bus.ADC_SCLK, bus.ADC_SDI}, 32'd0);
    chk("reset_sample", {16'd0, bus.sample_data, bus.sample_ch, bus.sample_valid}, 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;

    // Two-channel scan with upper mask bits ignored.
    wait_rises(2, 3000);
    chk("prime_no_strobe", 32'(st_ch.size()), 32'd0);
    wait_rises(4, 8000);
    tick(200);
    chk("strobe_count_a", 32'(st_ch.size()), 32'd3);
    chk("strobe0", {st_ch[0], st_data[0]}, {17'd0, 3'd1, 12'h123});
    chk("strobe1", {st_ch[1], st_data[1]}, {17'd0, 3'd0, 12'hABC});
    chk("strobe2", {st_ch[2], st_data[2]}, {17'd0, 3'd1, 12'h123});
    chk("convst_gap", 32'(last_gap), 32'd2500);
    chk("convst_len", 32'(conv_len), 32'd80);
    chk("sclk_pulses", 32'(frame_pulses), 32'd12);
    chk("sclk_period", 32'(bad_per), 32'd0);
    chk("cfg_ch1", 32'(cfg_q[0]), 32'h0C80);
    chk("cfg_ch0", 32'(cfg_q[1]), 32'h0880);
    chk("hold_data", {bus.sample_ch, bus.sample_data}, {17'd0, 3'd1, 12'h123});

    // Single channel: selection repeats ch0.
    bus.ch_mask = 8'h01;
    wait_rises(6, 5200);
    tick(200);
    chk("cfg_single_a", 32'(cfg_q[4]), 32'h0880);
    chk("cfg_single_b", 32'(cfg_q[5]), 32'h0880);
    chk("strobe_single_a", {st_ch[3], st_data[3]}, {17'd0, 3'd0, 12'hABC});
    chk("strobe_single_b", {st_ch[4], st_data[4]}, {17'd0, 3'd0, 12'hABC});

    // Only a mask bit beyond NUM_CH: effective mask empty.
    bus.ch_mask = 8'h04;
    snap_rise = rise_cnt;
    snap_busy = busy_hi;
    tick(3000);
    chk("empty_mask_convst", 32'(rise_cnt), 32'(snap_rise));
    chk("empty_mask_busy", 32'(busy_hi), 32'(snap_busy));

    // Restart primes, then drop enable during the next frame's SHIFT.
    bus.ch_mask = 8'h03;
    wait_rises(8, 3000);
    wait_pulses(3, 200);
    bus.enable = 1'b0;
    tick(3000);
    chk("disable_strobes", 32'(st_ch.size()), 32'd6);
    chk("disable_strobe", {st_ch[5], st_data[5]}, {17'd0, 3'd1, 12'h123});
    chk("disable_idle", 32'(rise_cnt), 32'd8);
    chk("disable_busy", 32'(bus.busy), 32'd0);
    bus.enable = 1'b1;
    wait_rises(9, 100);
    tick(200);
    chk("reenable_prime", 32'(st_ch.size()), 32'd6);
    wait_rises(10, 2600);
    tick(200);
    chk("reenable_strobe", {st_ch[6], st_data[6]}, {17'd0, 3'd1, 12'h123});

    // Back-to-back frames when the period is shorter than a frame.
    chk("fast_gap", 32'(f_bad), 32'd0);
    chk("fast_no_wait", 32'(f_idle), 32'd0);
    chk("fast_running", 32'(f_rise >= 100), 32'd1);

    // Asynchronous reset in the middle of SHIFT.
    wait_rises(11, 2600);
    wait_pulses(4, 200);
    snap_st = st_ch.size();
    rst_n = 1'b0;
    #1;
    chk("async_pins", {29'd0, bus.ADC_CONVST, bus.ADC_SCLK, bus.ADC_SDI}, 32'd0);
    chk("async_sample", {16'd0, bus.sample_data, bus.sample_ch, bus.sample_valid}, 32'd0);
    chk("async_busy", 32'(bus.busy), 32'd0);
    tick(5);
    rst_n = 1'b1;
    wait_rises(12, 100);
    tick(200);
    chk("post_reset_prime", 32'(st_ch.size()), 32'(snap_st));
    wait_rises(13, 2600);
    tick(200);
    chk("post_reset_strobe", {st_ch[snap_st], st_data[snap_st]}, {17'd0, 3'd1, 12'h123});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/adc_scan_scheduler.md
Name: adc_scan_scheduler

Overview:
- Sequences the board's serial 8-channel 12-bit ADC (CONVST/SCLK/SDI/SDO, LTC2308-style pipelined config word).
- Scans the enabled channels round-robin at a fixed sample rate.
- Presents each result as a tagged sample with a one-cycle valid strobe to downstream consumers (LED bar, PWM, moisture logic).

Parameters:
- CLK_DIV, 2: CLOCK_50 cycles per SCLK half-period (SCLK = 12.5 MHz).
- CONV_CYCLES, 80: cycles ADC_CONVST is held high (covers tCONV of 1.6 us).
- SAMPLE_PERIOD, 2500: cycles between successive CONVST rising edges (20 kS/s aggregate).
- NUM_CH, 2: number of physical channels scanned (1..8); mask bits at or above NUM_CH are ignored.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- RESET_N  in  1  asynchronous active-low reset.
- enable  in  1  scan enable, level.
- ch_mask  in  8  channel enable mask, bit n enables channel n.
- ADC_CONVST  out  1  conversion start.
- ADC_SCLK  out  1  serial clock, idles low.
- ADC_SDI  out  1  config word to ADC.
- ADC_SDO  in  1  data from ADC.
- sample_data  out  12  last result, unsigned.
- sample_ch  out  3  channel of sample_data.
- sample_valid  out  1  one-cycle strobe, new sample_data/sample_ch.
- busy  out  1  high while a frame is in progress.

Behaviour:
- Reset (async, RESET_N low): all outputs 0; state IDLE; period timer 0; prime flag set; current channel 0.
- Effective mask: em = ch_mask & ((1<<NUM_CH)-1). em is sampled once at frame start; changes mid-frame apply to the next frame.
- FSM states: IDLE -> CONV -> SHIFT -> DONE -> WAIT -> CONV ...
- IDLE:
  - Leave when enable=1 and em!=0 and the period timer has expired. The timer starts expired out of reset.
  - On exit, select next_ch = first enabled channel after cur_ch, modulo NUM_CH. With a single enabled channel, next_ch repeats it.
- CONV:
  - ADC_CONVST=1 for exactly CONV_CYCLES cycles.
  - The period timer restarts on the CONVST rising edge.
  - Then ADC_CONVST=0 and go to SHIFT.
- SHIFT:
  - 12 SCLK pulses; each half-period is CLK_DIV cycles.
  - ADC_SDI presents the config word MSB first, valid at least one half-period before the first rising edge, and updated on each SCLK falling edge.
  - Config word (bits 11..6): {1, next_ch[0], next_ch[2], next_ch[1], 1, 0}, i.e. single-ended, unipolar, no sleep. ADC_SDI=0 for bits 5..0.
  - ADC_SDO is sampled on each SCLK rising edge into a 12-bit MSB-first shift register.
  - Ends with SCLK low after the 12th falling edge.
- Pipelining: the word shifted in frame N selects the conversion of frame N+1. Data received in frame N belongs to the channel sent in frame N-1 (held as prev_ch).
- DONE (1 cycle):
  - If prime=0: sample_data <= shift register, sample_ch <= prev_ch, sample_valid=1 for this cycle only.
  - If prime=1: no strobe; clear prime.
  - Then prev_ch <= next_ch, cur_ch <= next_ch.
- WAIT:
  - Hold until the period timer expires, then go to CONV with the next channel selected.
  - If enable=0 or em=0, go to IDLE and set prime.
  - If the frame length (CONV_CYCLES + 24*CLK_DIV + 1 = 129 default) is at least SAMPLE_PERIOD, frames run back-to-back with no WAIT cycles.
- busy: 1 in CONV/SHIFT/DONE, 0 in IDLE/WAIT.
- Disable mid-frame: the current frame completes, including its sample_valid. It then returns to IDLE, with no truncated SCLK train.
- sample_data/sample_ch hold their value between strobes.

Test Plan:
- Defaults, em=2'b11, ADC model returns 0xABC for ch0 and 0x123 for ch1:
  - First frame produces no strobe.
  - Strobes then alternate (ch0, 0xABC), (ch1, 0x123).
  - CONVST rising edges are 2500 cycles apart.
  - CONVST stays high for 80 cycles.
  - Each frame has exactly 12 SCLK pulses of period 4 cycles.
- SDI check for next_ch=1: SDI bits are 1,1,0,0,1,0 then 0 x6. For next_ch=0: 1,0,0,0,1,0.
- ch_mask=0x01: every frame's config word selects ch0, and every strobe reports sample_ch=0. ch_mask=0x00: no CONVST, busy=0.
- Deassert enable during SHIFT: the frame finishes, one sample_valid is emitted, the FSM goes IDLE. Re-enable: the first frame is a priming frame with no strobe.
- Assert RESET_N low mid-SHIFT:
  - Immediately, all outputs are 0 and SCLK is low.
  - After release, the first frame produces no strobe.
- SAMPLE_PERIOD=64 (less than the 129-cycle frame): CONVST rising edges are 129 cycles apart and there are no WAIT cycles.
